// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for a zero-latency instruction memory: issues one
// instruction per cycle, honours stall and taken branches, and stops on the halt word.
module fetch_sequencer #(
  parameter int unsigned PC_BITS   = 12,
  parameter int unsigned CNT_BITS  = 16,
  parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_BITS-1:0]  start_pc,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_BITS-1:0]  branch_target,
  input  logic [2:0]          instr_op,
  input  logic [2:0]          instr_r1,
  input  logic [2:0]          instr_r2,
  output logic [PC_BITS-1:0]  pc,
  output logic                issue_valid,
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t state;
  logic   halt_seen;

  // A halt word fetched under stall is not yet final; it is re-examined once stall drops.
  assign halt_seen   = ({instr_op, instr_r1, instr_r2} == HALT_WORD) && !stall;
  assign busy        = (state == RUN);
  assign issue_valid = busy && !stall && !halt_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (halt_seen) begin
            state <= HALT;
            done  <= 1'b1;
          end else if (!stall) begin
            pc <= branch_taken ? branch_target : pc + PC_BITS'(1);
            if (instr_count != '1)
              instr_count <= instr_count + CNT_BITS'(1);
          end
        end
        default: begin
          if (start) begin
            pc          <= start_pc;
            instr_count <= '0;
            state       <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the main sequences plus a
// hand-written saturation run on a narrow-counter instance.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_taken;
  logic [11:0] start_pc, branch_target;
  logic [2:0]  op, r1, r2, op4, r14, r24;
  logic [11:0] pc, pc4;
  logic        issue_valid, busy, done, iv4, busy4, done4;
  logic [15:0] instr_count;
  logic [3:0]  cnt4;
  logic [8:0]  mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {op, r1, r2}    = mem[pc];
  assign {op4, r14, r24} = mem[pc4];

  fetch_sequencer #(.PC_BITS(12), .CNT_BITS(16), .HALT_WORD(9'h1FF)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_op(op), .instr_r1(r1), .instr_r2(r2),
    .pc(pc), .issue_valid(issue_valid), .busy(busy), .done(done), .instr_count(instr_count));

  fetch_sequencer #(.PC_BITS(12), .CNT_BITS(4), .HALT_WORD(9'h1FF)) dut4 (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_op(op4), .instr_r1(r14), .instr_r2(r24),
    .pc(pc4), .issue_valid(iv4), .busy(busy4), .done(done4), .instr_count(cnt4));

  typedef struct {
    logic        rst, st;
    logic [11:0] spc;
    logic        stl, br;
    logic [11:0] tgt;
    logic [11:0] e_pc;
    logic        e_iv, e_busy, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, st, input logic [11:0] spc, input logic stl, br,
                              input logic [11:0] tgt, e_pc, input logic e_iv, e_busy, e_done,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.spc = spc; v.stl = stl; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_iv = e_iv; v.e_busy = e_busy; v.e_done = e_done; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic rst, st, input logic [11:0] spc, input logic stl, br,
                       input logic [11:0] tgt);
    reset = rst; start = st; start_pc = spc; stall = stl; branch_taken = br; branch_target = tgt;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 9'o012;
    mem[12'h011] = 9'o345;
    mem[12'h012] = 9'h1FF;
    mem[12'h200] = 9'h1FF;
    mem[12'h614] = 9'h1FF;

    //          rst st spc    stl br tgt      pc     iv bz dn cnt
    vecs.push_back(mk(0, 1, 12'h010, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h010, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h011, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h012, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h012, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h012, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 12'h020, 0, 0, 12'h000, 12'h012, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h000, 12'h020, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h000, 12'h020, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h300, 12'h020, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h020, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 12'h500, 0, 0, 12'h000, 12'h021, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h030, 12'h022, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h100, 12'h030, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h100, 12'h030, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h100, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'hFFF, 12'h101, 1, 1, 0, 5));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'hFFF, 1, 1, 0, 6));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h200, 12'h000, 1, 1, 0, 7));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h000, 12'h200, 0, 1, 0, 8));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h050, 12'h200, 0, 1, 0, 8));
    vecs.push_back(mk(0, 1, 12'h040, 0, 0, 12'h000, 12'h200, 0, 0, 1, 8));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h040, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h041, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h042, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h043, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h044, 1, 1, 0, 4));
    vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h000, 12'h045, 1, 1, 0, 5));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0));

    drive(1, 0, 12'h000, 0, 0, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_cnt", 32'(instr_count), 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].st, vecs[i].spc, vecs[i].stl, vecs[i].br, vecs[i].tgt);
      #1;
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      check($sformatf("v%0d_issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d_cnt", i), 32'(instr_count), 32'(vecs[i].e_cnt));
    end

    // 20 non-halt words at 0x600..0x613, halt at 0x614: the 4-bit counter pins at 15.
    @(negedge clk);
    drive(0, 1, 12'h600, 0, 0, 12'h000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 0, 12'h000, 0, 0, 12'h000);
      #1;
      check($sformatf("sat%0d_pc", i), 32'(pc4), 32'(12'h600 + i));
      check($sformatf("sat%0d_iv", i), 32'(iv4), 32'h1);
      check($sformatf("sat%0d_cnt4", i), 32'(cnt4), 32'((i > 15) ? 15 : i));
      check($sformatf("sat%0d_cnt16", i), 32'(instr_count), 32'(i));
    end
    @(negedge clk);
    #1;
    check("sat_halt_pc", 32'(pc4), 32'h614);
    check("sat_halt_iv", 32'(iv4), 32'h0);
    check("sat_halt_cnt4", 32'(cnt4), 32'd15);
    check("sat_halt_cnt16", 32'(instr_count), 32'd20);
    begin
      int budget = 5;
      while (!done4 && budget > 0) begin
        @(negedge clk);
        #1;
        budget--;
      end
      check("sat_done_seen", 32'(done4), 32'h1);
    end
    check("sat_final_cnt4", 32'(cnt4), 32'd15);
    check("sat_final_pc", 32'(pc4), 32'h614);
    check("sat_final_busy", 32'(busy4), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller that sequences the combinational instruction memory (9-bit words: op[8:6], r1[5:3], r2[2:0]).
- Drives pc into the instruction memory and receives its decoded fields back in the same cycle.
- Issues one instruction per cycle to the downstream datapath; handles start, stall, taken branches and halt detection.
- Counts issued instructions for program-completion checking.

Parameters:
PC_BITS  12  width of program counter / instruction-memory address
CNT_BITS  16  width of issued-instruction counter
HALT_WORD  9'h1FF  encoding {op,r1,r2} that terminates the program

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begin execution at start_pc (honoured only in IDLE or HALT)
start_pc  input  PC_BITS  first instruction address, sampled with start
stall  input  1  datapath hazard; hold pc, issue nothing this cycle
branch_taken  input  1  execute stage redirects fetch this cycle
branch_target  input  PC_BITS  absolute redirect address, valid with branch_taken
instr_op  input  3  opcode field from instruction memory for current pc
instr_r1  input  3  reg1 field from instruction memory
instr_r2  input  3  reg2 field from instruction memory
pc  output  PC_BITS  current fetch address to instruction memory
issue_valid  output  1  current {instr_op,instr_r1,instr_r2} is a real instruction for the datapath
busy  output  1  high in RUN state
done  output  1  one-cycle pulse on entry to HALT
instr_count  output  CNT_BITS  instructions issued since last start (saturating)

Behaviour:
- States: IDLE, RUN, HALT. State register plus pc, instr_count and done registers; issue_valid and busy are combinational from state/inputs.
- Reset, synchronous, wins over everything:
  - state=IDLE, pc=0, instr_count=0, done=0.
  - Reset asserted mid-RUN abandons the program; no done pulse.
- IDLE/HALT:
  - issue_valid=0, busy=0, pc holds.
  - start=1: pc<=start_pc, instr_count<=0, state<=RUN.
  - start in RUN is ignored.
- RUN: busy=1. The instruction at pc is visible combinationally in the same cycle (zero-latency memory).
- RUN priority per cycle, highest first:
  1. Halt detect: {instr_op,instr_r1,instr_r2}==HALT_WORD and stall=0. Then issue_valid=0, state<=HALT, done<=1 next cycle for exactly one cycle, pc holds at the halt address, instr_count unchanged. Halt takes priority over a simultaneous branch_taken.
  2. stall=1: issue_valid=0, pc holds, count holds, branch_taken ignored. The producer must hold the branch until stall drops.
  3. branch_taken=1: issue_valid=1 for the current instruction, pc<=branch_target, count+1.
  4. Otherwise: issue_valid=1, pc<=pc+1, count+1.
- pc arithmetic is modulo 2^PC_BITS: increment from all-ones wraps to 0, no flag.
- instr_count saturates at 2^CNT_BITS-1 and never wraps.
- done is registered: it rises the cycle after the halt word is seen and clears the following cycle.
- A start in the same cycle as done=1 is legal and re-enters RUN.
- No X propagation: all outputs defined from the first post-reset edge.

Test Plan:
- Reset then start=1, start_pc=0x010; memory 0x010..0x012 = 9'o012, 9'o345, 9'h1FF -> pc 0x010, 0x011, 0x012; issue_valid 1,1,0; done pulse one cycle after pc=0x012; instr_count=2; state HALT, pc stays 0x012.
- RUN at pc=0x020, stall high 3 cycles -> pc stays 0x020, issue_valid=0, count unchanged; stall low -> pc 0x021 next edge.
- At pc=0x030 assert branch_taken, target=0x100 -> pc=0x100 next cycle, count +1. Repeat with stall=1 in the same cycle -> pc stays 0x030.
- start_pc=0xFFF (PC_BITS=12), non-halt word there -> pc wraps to 0x000, busy stays 1.
- Assert reset mid-RUN at pc=0x045 -> next cycle pc=0, busy=0, instr_count=0, done never pulses. start during RUN -> ignored, pc keeps incrementing.
- CNT_BITS=4, program of 20 non-halt words then halt -> instr_count saturates at 15. Halt word with simultaneous branch_taken -> HALT entered, pc not redirected.
